// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
// Holds the FSM state enum, the default word width and the bit-count width helper.
// No logic lives here; every user imports it with import sipo_pkg::*.
package sipo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Counter must hold 0..WIDTH inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/sipo_rx_if.sv
// Bundle of serial input, parallel output and status signals for sipo_rx.
// master = link driver plus word consumer; slave = the receiver itself.
// pready is the only backpressure; the serial side has none.
interface sipo_rx_if import sipo_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             sin;
  logic             sval;
  logic             sof;
  logic [WIDTH-1:0] pdata;
  logic             pvalid;
  logic             pready;
  logic             busy;
  logic             overrun;
  logic             ferr;
  logic             clr_err;

  modport master (
    output sin, sval, sof, pready, clr_err,
    input  pdata, pvalid, busy, overrun, ferr
  );

  modport slave (
    input  sin, sval, sof, pready, clr_err,
    output pdata, pvalid, busy, overrun, ferr
  );
endinterface

// File: rtl/sipo_shift.sv
// WIDTH-bit right shift register, new bit enters at the MSB.
// Latency: one cycle; nxt exposes the value q takes on the coming edge.
// No backpressure: en shifts unconditionally, clr has priority.
module sipo_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] nxt
);
  logic [WIDTH-1:0] q;

  // Next value: shifted when enabled, otherwise held.
  always_comb begin
    nxt = q;
    if (en) nxt = {din, q[WIDTH-1:1]};
  end

  // Register update with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) q <= '0;
    else     q <= nxt;
  end
endmodule

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver: frames on sof, collects WIDTH bits LSB first, holds one word.
// Latency: pdata/pvalid update on the edge that samples the last bit.
// Backpressure: a word completing while the held word is unaccepted is dropped and flagged.
module sipo_rx import sipo_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic     clk,
  input  logic     rst_n,
  sipo_rx_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] pdata_q;
  logic             pvalid_q;
  logic             busy_q;
  logic             overrun_q;
  logic             ferr_q;
  logic [WIDTH-1:0] word_nxt;
  logic             shift_en;

  // Bits shift only when framed: inside a frame, or the sof that opens one.
  assign shift_en = bus.sval && (state == RECV || bus.sof);

  sipo_shift #(.WIDTH(WIDTH)) u_shift (
    .clk (clk),
    .clr (!rst_n),
    .en  (shift_en),
    .din (bus.sin),
    .nxt (word_nxt)
  );

  // FSM, bit counter, holding register and sticky flags; later writes win so set beats clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      pdata_q   <= '0;
      pvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      if (bus.clr_err) begin
        overrun_q <= 1'b0;
        ferr_q    <= 1'b0;
      end
      if (pvalid_q && bus.pready) pvalid_q <= 1'b0;
      if (bus.sval) begin
        case (state)
          IDLE: begin
            if (bus.sof) begin
              state  <= RECV;
              count  <= CW'(1);
              busy_q <= 1'b1;
            end
          end
          RECV: begin
            if (bus.sof) begin
              // Abort the partial frame; this bit becomes bit 0 of a new one.
              ferr_q <= 1'b1;
              count  <= CW'(1);
            end else if (count == CW'(WIDTH - 1)) begin
              state  <= IDLE;
              count  <= '0;
              busy_q <= 1'b0;
              if (!pvalid_q || bus.pready) begin
                pdata_q  <= word_nxt;
                pvalid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              count <= count + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.pdata   = pdata_q;
  assign bus.pvalid  = pvalid_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;
  assign bus.ferr    = ferr_q;
endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx with WIDTH=4 and hand-computed expected words.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Each scenario task checks its own results inline.
module tb_sipo_rx;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  sipo_rx_if #(.WIDTH(4)) ifc ();

  sipo_rx #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic s);
    ifc.sin  = b;
    ifc.sval = 1'b1;
    ifc.sof  = s;
    tick();
    ifc.sval = 1'b0;
    ifc.sof  = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) send_bit(w[i], i == 0);
  endtask

  task automatic consume();
    ifc.pready = 1'b1;
    tick();
    ifc.pready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({ifc.pdata, ifc.pvalid, ifc.busy, ifc.overrun, ifc.ferr} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b exp 00000000",
               {ifc.pdata, ifc.pvalid, ifc.busy, ifc.overrun, ifc.ferr});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] bits;
    int bc;
    bits = 4'b1011;
    bc = 0;
    ifc.pready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_bit(bits[i], i == 0);
      if (ifc.busy === 1'b1) bc++;
    end
    checks++;
    if (ifc.pdata !== 4'b1011) begin
      errors++; $display("FAIL basic_pdata: got %b exp 1011", ifc.pdata);
    end
    checks++;
    if (ifc.pvalid !== 1'b1) begin
      errors++; $display("FAIL basic_pvalid: got %b exp 1", ifc.pvalid);
    end
    checks++;
    if (bc != 3) begin
      errors++; $display("FAIL basic_busy_cycles: got %0d exp 3", bc);
    end
    consume();
    checks++;
    if (ifc.pvalid !== 1'b0 || ifc.pdata !== 4'b1011) begin
      errors++; $display("FAIL basic_consume: got pvalid=%b pdata=%b exp 0 1011", ifc.pvalid, ifc.pdata);
    end
  endtask

  task automatic test_gap();
    logic [3:0] bits;
    int bad;
    bits = 4'b1011;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      send_bit(bits[i], i == 0);
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          ifc.sin = ~ifc.sin;
          ifc.sof = 1'b1;
          tick();
          if (ifc.busy !== 1'b1 || ifc.pvalid !== 1'b0 || ifc.ferr !== 1'b0) bad++;
        end
        ifc.sof = 1'b0;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL gap_hold: got %0d bad gap cycles exp 0", bad);
    end
    checks++;
    if (ifc.pdata !== 4'b1011 || ifc.pvalid !== 1'b1) begin
      errors++; $display("FAIL gap_word: got pdata=%b pvalid=%b exp 1011 1", ifc.pdata, ifc.pvalid);
    end
    consume();
  endtask

  task automatic test_overrun();
    ifc.pready = 1'b0;
    send_word(4'hA);
    send_word(4'h5);
    checks++;
    if (ifc.pdata !== 4'hA || ifc.pvalid !== 1'b1) begin
      errors++; $display("FAIL ovr_hold: got pdata=%h pvalid=%b exp a 1", ifc.pdata, ifc.pvalid);
    end
    checks++;
    if (ifc.overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_flag: got %b exp 1", ifc.overrun);
    end
    ifc.clr_err = 1'b1;
    tick();
    ifc.clr_err = 1'b0;
    checks++;
    if (ifc.overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_clear: got %b exp 0", ifc.overrun);
    end
    consume();
  endtask

  task automatic test_simul_accept();
    logic [3:0] w;
    send_word(4'h3);
    checks++;
    if (ifc.pdata !== 4'h3) begin
      errors++; $display("FAIL sim_first: got %h exp 3", ifc.pdata);
    end
    w = 4'hC;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) ifc.pready = 1'b1;
      send_bit(w[i], i == 0);
    end
    ifc.pready = 1'b0;
    checks++;
    if (ifc.pdata !== 4'hC || ifc.pvalid !== 1'b1 || ifc.overrun !== 1'b0) begin
      errors++;
      $display("FAIL sim_accept: got pdata=%h pvalid=%b overrun=%b exp c 1 0",
               ifc.pdata, ifc.pvalid, ifc.overrun);
    end
    consume();
  endtask

  task automatic test_early_sof();
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    ifc.clr_err = 1'b1;
    send_bit(1'b0, 1'b1);
    ifc.clr_err = 1'b0;
    checks++;
    if (ifc.ferr !== 1'b1 || ifc.busy !== 1'b1) begin
      errors++; $display("FAIL esof_flag: got ferr=%b busy=%b exp 1 1", ifc.ferr, ifc.busy);
    end
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    checks++;
    if (ifc.pdata !== 4'hE || ifc.pvalid !== 1'b1 || ifc.ferr !== 1'b1) begin
      errors++;
      $display("FAIL esof_word: got pdata=%h pvalid=%b ferr=%b exp e 1 1", ifc.pdata, ifc.pvalid, ifc.ferr);
    end
    ifc.clr_err = 1'b1;
    tick();
    ifc.clr_err = 1'b0;
    consume();
  endtask

  task automatic test_reset_mid();
    send_word(4'h9);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({ifc.pdata, ifc.pvalid, ifc.busy, ifc.overrun, ifc.ferr} !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_outputs: got %b exp 00000000",
               {ifc.pdata, ifc.pvalid, ifc.busy, ifc.overrun, ifc.ferr});
    end
    send_word(4'h6);
    checks++;
    if (ifc.pdata !== 4'h6 || ifc.pvalid !== 1'b1 || ifc.ferr !== 1'b0 || ifc.overrun !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_word: got pdata=%h pvalid=%b ferr=%b overrun=%b exp 6 1 0 0",
               ifc.pdata, ifc.pvalid, ifc.ferr, ifc.overrun);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    logic [3:0] w;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    checks++;
    if (ifc.busy !== 1'b0 || ifc.pvalid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle_ignore: got busy=%b pvalid=%b exp 0 0", ifc.busy, ifc.pvalid);
    end
    ifc.pready = 1'b1;
    send_word(4'h5);
    checks++;
    if (ifc.pdata !== 4'h5 || ifc.pvalid !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got pdata=%h pvalid=%b exp 5 1", ifc.pdata, ifc.pvalid);
    end
    w = 4'hA;
    send_bit(w[0], 1'b1);
    checks++;
    if (ifc.pvalid !== 1'b0 || ifc.busy !== 1'b1) begin
      errors++; $display("FAIL b2b_drain: got pvalid=%b busy=%b exp 0 1", ifc.pvalid, ifc.busy);
    end
    for (int i = 1; i < 4; i++) send_bit(w[i], 1'b0);
    checks++;
    if (ifc.pdata !== 4'hA || ifc.pvalid !== 1'b1 || ifc.overrun !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: got pdata=%h pvalid=%b overrun=%b exp a 1 0",
               ifc.pdata, ifc.pvalid, ifc.overrun);
    end
    ifc.pready = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    ifc.sin     = 1'b0;
    ifc.sval    = 1'b0;
    ifc.sof     = 1'b0;
    ifc.pready  = 1'b0;
    ifc.clr_err = 1'b0;
    test_reset();
    test_basic();
    test_gap();
    test_overrun();
    test_simul_accept();
    test_early_sof();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
